// File: rtl/sync_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_capture_fifo
// Description : Fast-domain capture FIFO released by edges of a slow,
//               asynchronous timing reference. slow_in is synchronised, edge
//               detected (rise / fall / both), and each detected edge pops
//               one buffered sample into a held output word with a one-cycle
//               strobe. Dropped pushes and empty pops raise sticky flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   Aclk         in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   slow_in      in   asynchronous slow clock / strobe level
//   din          in   sample to buffer (WIDTH)
//   din_valid    in   push din this cycle
//   clr_flags    in   synchronous clear of overflow / underrun
//   dout         out  held output word, changes only on a successful pop
//   dout_strobe  out  one-cycle pulse when dout takes a new value
//   count        out  FIFO occupancy 0..DEPTH
//   full         out  count == DEPTH
//   overflow     out  sticky: a push was dropped
//   underrun     out  sticky: an edge event found the FIFO empty
// ============================================================================
module sync_capture_fifo #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 3,
  parameter int EDGE_MODE   = 0
) (
  input  logic                     Aclk,
  input  logic                     reset,
  input  logic                     slow_in,
  input  logic [WIDTH-1:0]         din,
  input  logic                     din_valid,
  input  logic                     clr_flags,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_strobe,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic                     underrun
);

  localparam int                 c_ptr_w   = $clog2(DEPTH);
  localparam int                 c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // Synchroniser chain and edge history
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   w_s_last;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_event;

  // FIFO state
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wptr_q;
  logic [c_ptr_w-1:0] rptr_q;
  logic [c_cnt_w-1:0] count_q;
  logic [c_cnt_w-1:0] count_d;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Output and flag registers
  logic [WIDTH-1:0] dout_q;
  logic             strobe_q;
  logic             overflow_q;
  logic             overflow_d;
  logic             underrun_q;
  logic             underrun_d;

  assign w_s_last = sync_q[SYNC_STAGES-1];
  assign w_rise   = w_s_last & ~prev_q;
  assign w_fall   = ~w_s_last & prev_q;

  always_comb begin
    w_event = 1'b0;
    case (EDGE_MODE)
      0:       w_event = w_rise;
      1:       w_event = w_fall;
      default: w_event = w_rise | w_fall;
    endcase
  end

  assign w_full  = (count_q == c_depth);
  assign w_empty = (count_q == '0);
  assign w_pop   = w_event & ~w_empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign w_push  = din_valid & (~w_full | w_pop);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_one;
      2'b01:   count_d = count_q - c_cnt_one;
      default: count_d = count_q;
    endcase
  end

  // Set conditions take priority over clr_flags.
  assign overflow_d = (din_valid & w_full & ~w_pop) | (overflow_q & ~clr_flags);
  assign underrun_d = (w_event & w_empty) | (underrun_q & ~clr_flags);

  always_ff @(posedge Aclk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      dout_q     <= '0;
      strobe_q   <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], slow_in};
      prev_q     <= w_s_last;
      count_q    <= count_d;
      strobe_q   <= w_pop;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      if (w_push) begin
        wptr_q <= wptr_q + c_ptr_one;
      end
      if (w_pop) begin
        // Reads the pre-edge head, so a same-cycle write to that slot is safe.
        dout_q <= mem_q[rptr_q];
        rptr_q <= rptr_q + c_ptr_one;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge Aclk) begin
    if (w_push) begin
      mem_q[wptr_q] <= din;
    end
  end

  assign dout        = dout_q;
  assign dout_strobe = strobe_q;
  assign count       = count_q;
  assign full        = w_full;
  assign overflow    = overflow_q;
  assign underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_capture_fifo
// Description : Self-checking bench for sync_capture_fifo. Three instances
//               share stimulus: dut0 defaults (rising, 3 stages), dut1
//               falling edges, dut2 both edges with 2 stages. A queue-style
//               reference model predicts every output of every instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_capture_fifo;

  logic       Aclk = 1'b0;
  logic       reset = 1'b1;
  logic       slow_in = 1'b0;
  logic [3:0] din = 4'h0;
  logic       din_valid = 1'b0;
  logic       clr_flags = 1'b0;

  logic [2:0][3:0] dout_w;
  logic [2:0][2:0] cnt_w;
  logic [2:0]      stb_w;
  logic [2:0]      full_w;
  logic [2:0]      ovf_w;
  logic [2:0]      und_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Aclk = ~Aclk;

  sync_capture_fifo #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(3), .EDGE_MODE(0)) u_dut0 (
    .Aclk(Aclk), .reset(reset), .slow_in(slow_in), .din(din), .din_valid(din_valid),
    .clr_flags(clr_flags), .dout(dout_w[0]), .dout_strobe(stb_w[0]), .count(cnt_w[0]),
    .full(full_w[0]), .overflow(ovf_w[0]), .underrun(und_w[0]));

  sync_capture_fifo #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(3), .EDGE_MODE(1)) u_dut1 (
    .Aclk(Aclk), .reset(reset), .slow_in(slow_in), .din(din), .din_valid(din_valid),
    .clr_flags(clr_flags), .dout(dout_w[1]), .dout_strobe(stb_w[1]), .count(cnt_w[1]),
    .full(full_w[1]), .overflow(ovf_w[1]), .underrun(und_w[1]));

  sync_capture_fifo #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(2), .EDGE_MODE(2)) u_dut2 (
    .Aclk(Aclk), .reset(reset), .slow_in(slow_in), .din(din), .din_valid(din_valid),
    .clr_flags(clr_flags), .dout(dout_w[2]), .dout_strobe(stb_w[2]), .count(cnt_w[2]),
    .full(full_w[2]), .overflow(ovf_w[2]), .underrun(und_w[2]));

  // ---------------- reference model ----------------
  // hist[k] is slow_in as sampled k edges ago (hist[0] = this edge).
  // mbuf[i][0] is the oldest entry; a pop shifts the list down.
  logic       hist [8];
  logic [3:0] mbuf [3][4];
  int         mcnt [3];
  logic [3:0] mdout [3];
  logic       mstb [3];
  logic       movf [3];
  logic       mund [3];

  function automatic int stages_of(int i);
    return (i == 2) ? 2 : 3;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0; mdout[i] = 4'h0; mstb[i] = 1'b0; movf[i] = 1'b0; mund[i] = 1'b0;
      for (int k = 0; k < 4; k++) mbuf[i][k] = 4'h0;
    end
  endtask

  task automatic model_edge();
    logic cur, prv, ev;
    int   pre;
    if (reset) begin
      model_clear();
    end else begin
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = slow_in;
      for (int i = 0; i < 3; i++) begin
        cur = hist[stages_of(i)];
        prv = hist[stages_of(i) + 1];
        case (i)
          0:       ev = cur & ~prv;
          1:       ev = ~cur & prv;
          default: ev = cur ^ prv;
        endcase
        pre     = mcnt[i];
        mstb[i] = 1'b0;
        if (ev && pre > 0) begin
          mdout[i] = mbuf[i][0];
          for (int k = 0; k < 3; k++) mbuf[i][k] = mbuf[i][k+1];
          mcnt[i]--;
          mstb[i] = 1'b1;
        end
        if (ev && pre == 0) mund[i] = 1'b1;
        else if (clr_flags) mund[i] = 1'b0;
        if (din_valid && mcnt[i] < 4) begin
          mbuf[i][mcnt[i]] = din;
          mcnt[i]++;
          if (clr_flags) movf[i] = 1'b0;
        end else if (din_valid) begin
          movf[i] = 1'b1;
        end else if (clr_flags) begin
          movf[i] = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [10:0] expv(int i);
    return {mdout[i], mstb[i], 3'(mcnt[i]), (mcnt[i] == 4), movf[i], mund[i]};
  endfunction

  function automatic logic [10:0] obsv(int i);
    return {dout_w[i], stb_w[i], cnt_w[i], full_w[i], ovf_w[i], und_w[i]};
  endfunction

  // Advance one clock: model follows the edge, outputs are read on the falling edge.
  task automatic tick();
    @(posedge Aclk);
    model_edge();
    @(negedge Aclk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obsv(i) !== 11'h0) begin
        n_bad++; $display("FAIL reset dut%0d got %h exp 000", i, obsv(i));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] vals [3];
    vals = '{4'h3, 4'h5, 4'h9};
    din_valid = 1'b1;
    for (int v = 0; v < 3; v++) begin
      din = vals[v];
      tick();
    end
    din_valid = 1'b0;
    slow_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL basic dut%0d k=%0d got %h exp %h", i, k, obsv(i), expv(i));
        end
      end
      n_cmp++;
      if (stb_w[0] !== (k == 4) || stb_w[2] !== (k == 3) || stb_w[1] !== 1'b0) begin
        n_bad++; $display("FAIL basic_latency k=%0d got strobes %b", k, stb_w);
      end
    end
    n_cmp++;
    if (dout_w[0] !== 4'h3 || cnt_w[0] !== 3'd2) begin
      n_bad++; $display("FAIL basic_first got dout %h count %0d exp 3 / 2", dout_w[0], cnt_w[0]);
    end
    for (int r = 1; r < 3; r++) begin
      slow_in = 1'b0;
      repeat (6) tick();
      slow_in = 1'b1;
      repeat (6) begin
        tick();
        for (int i = 0; i < 3; i++) begin
          n_cmp++;
          if (obsv(i) !== expv(i)) begin
            n_bad++; $display("FAIL basic dut%0d r=%0d got %h exp %h", i, r, obsv(i), expv(i));
          end
        end
      end
      n_cmp++;
      if (dout_w[0] !== vals[r]) begin
        n_bad++; $display("FAIL basic_pop got %h exp %h", dout_w[0], vals[r]);
      end
    end
    n_cmp++;
    if (cnt_w[0] !== 3'd0) begin
      n_bad++; $display("FAIL basic_empty got count %0d exp 0", cnt_w[0]);
    end
  endtask

  task automatic test_overflow();
    slow_in = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    din_valid = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      din = 4'(v);
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL overflow dut%0d got %h exp %h", i, obsv(i), expv(i));
        end
      end
    end
    din_valid = 1'b0;
    n_cmp++;
    if (cnt_w[0] !== 3'd4 || full_w[0] !== 1'b1 || ovf_w[0] !== 1'b1) begin
      n_bad++; $display("FAIL overflow_set got count %0d full %b ovf %b exp 4 1 1", cnt_w[0], full_w[0], ovf_w[0]);
    end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_cmp++;
    if (ovf_w[0] !== 1'b0) begin
      n_bad++; $display("FAIL overflow_clr got %b exp 0", ovf_w[0]);
    end
    for (int r = 0; r < 4; r++) begin
      slow_in = 1'b1;
      repeat (4) tick();
      n_cmp++;
      if (dout_w[0] !== 4'(r + 1) || stb_w[0] !== 1'b1) begin
        n_bad++; $display("FAIL overflow_pop got %h stb %b exp %h 1", dout_w[0], stb_w[0], 4'(r + 1));
      end
      slow_in = 1'b0;
      repeat (6) begin
        tick();
        for (int i = 0; i < 3; i++) begin
          n_cmp++;
          if (obsv(i) !== expv(i)) begin
            n_bad++; $display("FAIL overflow dut%0d got %h exp %h", i, obsv(i), expv(i));
          end
        end
      end
    end
    n_cmp++;
    if (cnt_w[0] !== 3'd0) begin
      n_bad++; $display("FAIL overflow_drain got count %0d exp 0", cnt_w[0]);
    end
  endtask

  task automatic test_underrun();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    slow_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      clr_flags = (k == 4);
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL underrun dut%0d k=%0d got %h exp %h", i, k, obsv(i), expv(i));
        end
      end
      n_cmp++;
      if (und_w[0] !== (k == 4)) begin
        n_bad++; $display("FAIL underrun_set k=%0d got %b exp %b", k, und_w[0], (k == 4));
      end
    end
    clr_flags = 1'b0;
    n_cmp++;
    if (dout_w[0] !== 4'h4 || stb_w[0] !== 1'b0) begin
      n_bad++; $display("FAIL underrun_hold got %h stb %b exp 4 0", dout_w[0], stb_w[0]);
    end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    n_cmp++;
    if (und_w[0] !== 1'b0) begin
      n_bad++; $display("FAIL underrun_clr got %b exp 0", und_w[0]);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seq [4];
    seq = '{4'hC, 4'hD, 4'hE, 4'hA};
    slow_in = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    din_valid = 1'b1;
    for (int v = 0; v < 4; v++) begin
      din = 4'(4'hB + v);
      tick();
    end
    din_valid = 1'b0;
    slow_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din_valid = (k == 4);
      din = 4'hA;
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL simul dut%0d k=%0d got %h exp %h", i, k, obsv(i), expv(i));
        end
      end
    end
    din_valid = 1'b0;
    n_cmp++;
    if (cnt_w[0] !== 3'd4 || ovf_w[0] !== 1'b0 || dout_w[0] !== 4'hB) begin
      n_bad++; $display("FAIL simul_full got count %0d ovf %b dout %h exp 4 0 b", cnt_w[0], ovf_w[0], dout_w[0]);
    end
    for (int r = 0; r < 4; r++) begin
      slow_in = 1'b0;
      repeat (6) tick();
      slow_in = 1'b1;
      repeat (4) tick();
      n_cmp++;
      if (dout_w[0] !== seq[r]) begin
        n_bad++; $display("FAIL simul_pop r=%0d got %h exp %h", r, dout_w[0], seq[r]);
      end
    end
    slow_in = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    repeat (5) tick();
    slow_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din_valid = (k == 4);
      din = 4'h7;
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL simul_empty dut%0d k=%0d got %h exp %h", i, k, obsv(i), expv(i));
        end
      end
    end
    din_valid = 1'b0;
    n_cmp++;
    if (und_w[0] !== 1'b1 || cnt_w[0] !== 3'd1 || stb_w[0] !== 1'b0) begin
      n_bad++; $display("FAIL simul_empty_push got und %b count %0d stb %b exp 1 1 0", und_w[0], cnt_w[0], stb_w[0]);
    end
  endtask

  task automatic test_edge_modes();
    int pops [3];
    pops = '{0, 0, 0};
    din_valid = 1'b1;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 16; c++) begin
        slow_in = (c >= 8);
        din = 4'($urandom);
        tick();
        for (int i = 0; i < 3; i++) begin
          n_cmp++;
          if (obsv(i) !== expv(i)) begin
            n_bad++; $display("FAIL edges dut%0d p=%0d c=%0d got %h exp %h", i, p, c, obsv(i), expv(i));
          end
          if (p > 0 && stb_w[i]) pops[i]++;
        end
      end
    end
    din_valid = 1'b0;
    n_cmp++;
    if (pops[0] !== 4 || pops[1] !== 4 || pops[2] !== 8) begin
      n_bad++; $display("FAIL edges_rate got %0d/%0d/%0d exp 4/4/8", pops[0], pops[1], pops[2]);
    end
  endtask

  task automatic test_random();
    int hold = 1;
    for (int c = 0; c < 400; c++) begin
      din_valid = ($urandom_range(0, 2) != 0);
      din       = 4'($urandom);
      clr_flags = ($urandom_range(0, 15) == 0);
      hold--;
      if (hold == 0) begin
        slow_in = ~slow_in;
        hold = $urandom_range(1, 10);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL random dut%0d c=%0d got %h exp %h", i, c, obsv(i), expv(i));
        end
      end
    end
    din_valid = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic test_reset_mid();
    slow_in = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    din_valid = 1'b1;
    for (int v = 0; v < 3; v++) begin
      din = 4'(v + 6);
      tick();
    end
    din_valid = 1'b0;
    n_cmp++;
    if (cnt_w[0] !== 3'd3) begin
      n_bad++; $display("FAIL reset_mid_fill got count %0d exp 3", cnt_w[0]);
    end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obsv(i) !== 11'h0) begin
        n_bad++; $display("FAIL reset_async dut%0d got %h exp 000", i, obsv(i));
      end
    end
    slow_in = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL reset_rel dut%0d k=%0d got %h exp %h", i, k, obsv(i), expv(i));
        end
      end
      n_cmp++;
      if (und_w[0] !== (k >= 4) || stb_w[0] !== 1'b0) begin
        n_bad++; $display("FAIL reset_rise k=%0d got und %b stb %b exp %b 0", k, und_w[0], stb_w[0], (k >= 4));
      end
    end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    repeat (12) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obsv(i) !== expv(i)) begin
          n_bad++; $display("FAIL reset_quiet dut%0d got %h exp %h", i, obsv(i), expv(i));
        end
      end
    end
    n_cmp++;
    if (und_w[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_single_event got und %b exp 0", und_w[0]);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_underrun();
    test_simultaneous();
    test_edge_modes();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
